vga_sync_receiver: RTL and testbench
====================================

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 The block SHALL have clock clk and reset reset, asynchronous, active-high.
REQ-002 Ports SHALL be:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- pix_en  in  1  pixel strobe; one-clk pulse per pixel
- h_sync_in  in  1  horizontal sync, active-low
- v_sync_in  in  1  vertical sync, active-low
- x_pixel  out  10  recovered column, 0..639
- y_pixel  out  10  recovered row, 0..479
- DE  out  1  visible-pixel enable
- frame_start  out  1  one-clk pulse on pixel (0,0)
- locked  out  1  timing lock indicator
- timing_err  out  1  one-clk pulse on a timing violation while locked
- h_total  out  10  last measured line length in pixels
- v_total  out  10  last measured frame length in lines

Function
REQ-003 All state SHALL advance only on clk edges with pix_en=1; with pix_en=0 all registers SHALL hold, and pulses SHALL be cleared.
REQ-004 Each sync input SHALL be registered once per pix_en; a falling edge is prev=1 and cur=0 on a pix_en cycle.
REQ-005 h_count (10 bits) SHALL reset to 0 on an h_sync falling edge, otherwise increment, saturating at 1023; on that edge h_total SHALL load h_count+1.
REQ-006 A v_sync falling edge SHALL arm a flag; the next h_sync falling edge SHALL load v_line=0 and v_total=v_line+1, then clear the flag; any other h_sync edge increments v_line, saturating at 1023.
REQ-007 The FSM SHALL have states SEARCH, ACQUIRE and LOCKED.
- SEARCH->ACQUIRE on the first armed v_line reload; good_cnt=0.
- ACQUIRE: each reload with h_total==800 and v_total==525 increments good_cnt; a mismatch returns to SEARCH; good_cnt==LOCK_FRAMES (2) moves to LOCKED.
- LOCKED: any h_total!=800 or v_total!=525, or h_count reaching 1023, SHALL pulse timing_err and go to SEARCH.
- Reaching h_count==1023 in ACQUIRE SHALL also go to SEARCH, without timing_err.
REQ-008 locked SHALL be 1 only in LOCKED.
REQ-009 DE SHALL be locked && 144<=h_count<=783 && 34<=v_line<=513; in that case x_pixel=h_count-144 and y_pixel=v_line-34, otherwise both SHALL be 0.
REQ-010 Outputs SHALL be registered: one clk latency from the pix_en sample.
REQ-011 frame_start SHALL pulse when DE=1, x=0 and y=0.
REQ-012 Simultaneous h and v falling edges SHALL apply the v arm first, so that the same h edge performs the reload.

Reset
REQ-013 With reset=1, all outputs SHALL be 0, the FSM SHALL be SEARCH, counters and flags SHALL be 0, and the registered sync values SHALL be 1, with immediate effect independent of clk.
REQ-014 Reset asserted mid-frame SHALL force DE=0 and locked=0 immediately; reacquisition SHALL need a full SEARCH/ACQUIRE sequence.

Configuration
REQ-015 With macro VGA_RX_ERR_CNT_EN defined, the block SHALL add output err_count[7:0], which increments on each timing_err, saturates at 255 and resets to 0.
REQ-016 Without the macro, the err_count port and its logic SHALL be absent.

Structure
REQ-017 Package vga_rx_pkg SHALL hold H_TOTAL=800, V_TOTAL=525, H_OFS=144, V_OFS=34, H_VIS=640, V_VIS=480, LOCK_FRAMES=2, and typedef enum rx_state_t.
REQ-018 Sub-module vga_sync_edge (register plus falling-edge detect, reset value 1) SHALL be instantiated once per sync input.

Verification
REQ-019 Reset, then 3 standard 800x525 frames (active-low sync at h 656..751, v 490..491, pix_en every 4th clk) -> locked rises on the 2nd frame reload after SEARCH exit; 307200 DE pixels per locked frame; first DE has x=0, y=0 with frame_start.
REQ-020 While locked, one 799-pixel line -> timing_err single pulse, locked=0, h_total=799; reacquired after 3 good frames.
REQ-021 h_sync held high for 1100 strobes while locked -> timing_err pulse at h_count=1023, FSM in SEARCH.
REQ-022 Reset asserted mid-visible line -> DE, locked, x_pixel and y_pixel all 0 without waiting for a clk edge.
REQ-023 pix_en with random gaps of 1-6 clks -> identical x, y and DE sequence to the regular-strobe run.
REQ-024 With VGA_RX_ERR_CNT_EN defined, 300 induced errors -> err_count=255.

Source files
------------

// File: rtl/vga_rx_pkg.sv
// Shared constants, state type and helpers for the VGA sync receiver.
package vga_rx_pkg;

    localparam int H_TOTAL     = 800;
    localparam int V_TOTAL     = 525;
    localparam int H_OFS       = 144;
    localparam int V_OFS       = 34;
    localparam int H_VIS       = 640;
    localparam int V_VIS       = 480;
    localparam int LOCK_FRAMES = 2;

    localparam logic [9:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } rx_state_t;

    // Saturating 10-bit increment used by every measurement counter.
    function automatic logic [9:0] sat_inc(input logic [9:0] value);
        return (value == CNT_MAX) ? CNT_MAX : value + 10'd1;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Samples one active-low sync line per pixel strobe and flags its falling edge.
module vga_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic pix_en,
    input  logic sync,
    output logic fall
);

    logic sync_reg;

    // Idle level of an active-low sync is high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= 1'b1;
        end else if (pix_en) begin
            sync_reg <= sync;
        end
    end

    assign fall = pix_en & sync_reg & ~sync;

endmodule

// File: rtl/vga_sync_receiver.sv
// Recovers pixel coordinates and lock status from VGA h/v sync.
// Define VGA_RX_ERR_CNT_EN to add the saturating err_count output.
module vga_sync_receiver
    import vga_rx_pkg::*;
#(
    parameter int LINE_PIXELS = H_TOTAL,
    parameter int FRAME_LINES = V_TOTAL,
    parameter int H_START     = H_OFS,
    parameter int V_START     = V_OFS,
    parameter int H_ACTIVE    = H_VIS,
    parameter int V_ACTIVE    = V_VIS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    output logic [9:0] x_pixel,
    output logic [9:0] y_pixel,
    output logic       DE,
    output logic       frame_start,
    output logic       locked,
    output logic       timing_err,
    output logic [9:0] h_total,
`ifdef VGA_RX_ERR_CNT_EN
    output logic [9:0] v_total,
    output logic [7:0] err_count
`else
    output logic [9:0] v_total
`endif
);

    localparam logic [9:0] LINE_LEN  = 10'(LINE_PIXELS);
    localparam logic [9:0] FRAME_LEN = 10'(FRAME_LINES);
    localparam logic [9:0] H_FIRST   = 10'(H_START);
    localparam logic [9:0] H_LAST    = 10'(H_START + H_ACTIVE - 1);
    localparam logic [9:0] V_FIRST   = 10'(V_START);
    localparam logic [9:0] V_LAST    = 10'(V_START + V_ACTIVE - 1);
    localparam logic [1:0] LOCK_LAST = 2'(LOCK_FRAMES - 1);

    logic [1:0] sync_vec;
    logic [1:0] fall_vec;
    logic       h_fall;
    logic       v_fall;

    assign sync_vec = {v_sync_in, h_sync_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            vga_sync_edge u_edge (
                .clk   (clk),
                .reset (reset),
                .pix_en(pix_en),
                .sync  (sync_vec[gi]),
                .fall  (fall_vec[gi])
            );
        end
    endgenerate

    assign h_fall = fall_vec[0];
    assign v_fall = fall_vec[1];

    logic [9:0] h_count_reg, h_count_next;
    logic [9:0] v_line_reg, v_line_next;
    logic [9:0] h_total_next, v_total_next;
    logic       v_armed_reg, v_armed_next;
    logic       reload;
    logic [1:0] good_cnt_reg, good_cnt_next;
    rx_state_t  state_reg, state_next;
    logic       err_next;
    logic       de_next;
    logic       frame_start_next;
    logic [9:0] x_next, y_next;

    // A v edge arriving with the h edge still counts, so that h edge reloads the frame.
    always_comb begin
        reload       = h_fall & (v_armed_reg | v_fall);
        h_count_next = h_fall ? 10'd0 : sat_inc(h_count_reg);
        h_total_next = h_fall ? sat_inc(h_count_reg) : h_total;
        v_line_next  = reload ? 10'd0 : (h_fall ? sat_inc(v_line_reg) : v_line_reg);
        v_total_next = reload ? sat_inc(v_line_reg) : v_total;
        v_armed_next = ~reload & (v_armed_reg | v_fall);
    end

    always_comb begin
        state_next    = state_reg;
        good_cnt_next = good_cnt_reg;
        err_next      = 1'b0;
        case (state_reg)
            SEARCH: begin
                if (reload) begin
                    state_next    = ACQUIRE;
                    good_cnt_next = 2'd0;
                end
            end
            ACQUIRE: begin
                if (h_count_next == CNT_MAX) begin
                    state_next = SEARCH;
                end else if (reload) begin
                    if (h_total_next == LINE_LEN && v_total_next == FRAME_LEN) begin
                        if (good_cnt_reg == LOCK_LAST) begin
                            state_next = LOCKED;
                        end else begin
                            good_cnt_next = good_cnt_reg + 2'd1;
                        end
                    end else begin
                        state_next = SEARCH;
                    end
                end
            end
            LOCKED: begin
                if (h_count_next == CNT_MAX ||
                    (h_fall && h_total_next != LINE_LEN) ||
                    (reload && v_total_next != FRAME_LEN)) begin
                    err_next   = 1'b1;
                    state_next = SEARCH;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    always_comb begin
        de_next = (state_next == LOCKED) &&
                  (h_count_next >= H_FIRST) && (h_count_next <= H_LAST) &&
                  (v_line_next >= V_FIRST) && (v_line_next <= V_LAST);
        x_next           = de_next ? h_count_next - H_FIRST : 10'd0;
        y_next           = de_next ? v_line_next - V_FIRST : 10'd0;
        frame_start_next = de_next && (x_next == 10'd0) && (y_next == 10'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_count_reg  <= 10'd0;
            v_line_reg   <= 10'd0;
            v_armed_reg  <= 1'b0;
            good_cnt_reg <= 2'd0;
            state_reg    <= SEARCH;
            h_total      <= 10'd0;
            v_total      <= 10'd0;
            x_pixel      <= 10'd0;
            y_pixel      <= 10'd0;
            DE           <= 1'b0;
            frame_start  <= 1'b0;
            locked       <= 1'b0;
            timing_err   <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            timing_err  <= 1'b0;
            if (pix_en) begin
                h_count_reg  <= h_count_next;
                v_line_reg   <= v_line_next;
                v_armed_reg  <= v_armed_next;
                good_cnt_reg <= good_cnt_next;
                state_reg    <= state_next;
                h_total      <= h_total_next;
                v_total      <= v_total_next;
                x_pixel      <= x_next;
                y_pixel      <= y_next;
                DE           <= de_next;
                frame_start  <= frame_start_next;
                locked       <= (state_next == LOCKED);
                timing_err   <= err_next;
            end
        end
    end

`ifdef VGA_RX_ERR_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= 8'd0;
        end else if (pix_en && err_next && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Randomized self-checking bench for vga_sync_receiver on a scaled-down 8x6 raster.
module tb_vga_sync_receiver;
    import vga_rx_pkg::*;

    // Scaled raster: 4 visible px, sync at px 5; 3 visible lines, sync at line 4.
    localparam int HT = 8;
    localparam int VT = 6;
    localparam int HS = 5;
    localparam int VS = 4;
    localparam int HO = HT - HS;
    localparam int VO = VT - VS - 1;
    localparam int HV = 4;
    localparam int VV = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_en;
    logic       h_sync_in;
    logic       v_sync_in;
    logic [9:0] x_pixel;
    logic [9:0] y_pixel;
    logic       DE;
    logic       frame_start;
    logic       locked;
    logic       timing_err;
    logic [9:0] h_total;
    logic [9:0] v_total;
`ifdef VGA_RX_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    always #5 clk = ~clk;

    vga_sync_receiver #(
        .LINE_PIXELS(HT),
        .FRAME_LINES(VT),
        .H_START    (HO),
        .V_START    (VO),
        .H_ACTIVE   (HV),
        .V_ACTIVE   (VV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .x_pixel    (x_pixel),
        .y_pixel    (y_pixel),
        .DE         (DE),
        .frame_start(frame_start),
        .locked     (locked),
        .timing_err (timing_err),
        .h_total    (h_total),
`ifdef VGA_RX_ERR_CNT_EN
        .v_total    (v_total),
        .err_count  (err_count)
`else
        .v_total    (v_total)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: unbounded pixel/line counts since the last sync edges,
    // lock progress as a count of validated frames (-1 = searching).
    int m_prev_h, m_prev_v, m_pix, m_lines, m_armed, m_hlen, m_vlen, m_good, m_errs;
    int e_x, e_y, e_de, e_fs, e_lock, e_err;

    task automatic model_reset();
        m_prev_h = 1; m_prev_v = 1; m_pix = 0; m_lines = 0; m_armed = 0;
        m_hlen = 0; m_vlen = 0; m_good = -1; m_errs = 0;
        e_x = 0; e_y = 0; e_de = 0; e_fs = 0; e_lock = 0; e_err = 0;
    endtask

    task automatic model_step(input int h, input int v);
        int hf, vf, rl, hc, vl;
        hf = (m_prev_h == 1 && h == 0) ? 1 : 0;
        vf = (m_prev_v == 1 && v == 0) ? 1 : 0;
        m_prev_h = h;
        m_prev_v = v;
        if (vf == 1) m_armed = 1;
        if (hf == 1) begin
            m_hlen = (m_pix + 1 > 1023) ? 1023 : m_pix + 1;
            m_pix  = 0;
        end else begin
            m_pix++;
        end
        rl = (hf == 1 && m_armed == 1) ? 1 : 0;
        if (rl == 1) begin
            m_vlen  = (m_lines + 1 > 1023) ? 1023 : m_lines + 1;
            m_lines = 0;
            m_armed = 0;
        end else if (hf == 1) begin
            m_lines++;
        end
        hc = (m_pix > 1023) ? 1023 : m_pix;
        vl = (m_lines > 1023) ? 1023 : m_lines;
        e_err = 0;
        if (m_good < 0) begin
            if (rl == 1) m_good = 0;
        end else if (m_good < LOCK_FRAMES) begin
            if (hc == 1023) m_good = -1;
            else if (rl == 1) m_good = (m_hlen == HT && m_vlen == VT) ? m_good + 1 : -1;
        end else if (hc == 1023 || (hf == 1 && m_hlen != HT) || (rl == 1 && m_vlen != VT)) begin
            e_err  = 1;
            m_good = -1;
            if (m_errs < 255) m_errs++;
        end
        e_lock = (m_good == LOCK_FRAMES) ? 1 : 0;
        e_de   = (e_lock == 1 && hc >= HO && hc < HO + HV && vl >= VO && vl < VO + VV) ? 1 : 0;
        e_x    = (e_de == 1) ? hc - HO : 0;
        e_y    = (e_de == 1) ? vl - VO : 0;
        e_fs   = (e_de == 1 && e_x == 0 && e_y == 0) ? 1 : 0;
    endtask

    int gap_mode = 0;         // 0: every 4th clk, 1: random 1-6 clk period, 2: continuous
    int err_pulses = 0;
    int err_htotal = 0;
    int de_count = 0;
    int seen_de = 0;
    int first_x = 0, first_y = 0, first_fs = 0;
    int rec_mode = 0;         // 1: record expected x/y/DE, 2: compare against the recording
    int rec_q[$];

    // Called at a negedge; returns at a negedge.
    task automatic strobe(input int h, input int v);
        int idle, packed_exp;
        idle = (gap_mode == 0) ? 3 : (gap_mode == 1) ? int'($urandom_range(0, 5)) : 0;
        pix_en    = 1'b1;
        h_sync_in = h[0];
        v_sync_in = v[0];
        model_step(h, v);
        @(negedge clk);
        check("x_pixel", int'(x_pixel), e_x);
        check("y_pixel", int'(y_pixel), e_y);
        check("DE", int'(DE), e_de);
        check("frame_start", int'(frame_start), e_fs);
        check("locked", int'(locked), e_lock);
        check("timing_err", int'(timing_err), e_err);
        check("h_total", int'(h_total), m_hlen);
        check("v_total", int'(v_total), m_vlen);
`ifdef VGA_RX_ERR_CNT_EN
        check("err_count", int'(err_count), m_errs);
`endif
        if (timing_err) begin
            err_pulses++;
            err_htotal = int'(h_total);
        end
        if (DE) begin
            de_count++;
            if (seen_de == 0) begin
                seen_de  = 1;
                first_x  = int'(x_pixel);
                first_y  = int'(y_pixel);
                first_fs = int'(frame_start);
            end
        end
        packed_exp = (e_de << 20) | (e_x << 10) | e_y;
        if (rec_mode == 1) rec_q.push_back(packed_exp);
        if (rec_mode == 2) begin
            if (rec_q.size() == 0) check("replay_len", 0, 1);
            else check("replay_xyde", (int'(DE) << 20) | (int'(x_pixel) << 10) | int'(y_pixel),
                       rec_q.pop_front());
        end
        pix_en = 1'b0;
        for (int i = 0; i < idle; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("frame_start_clear", int'(frame_start), 0);
                check("timing_err_clear", int'(timing_err), 0);
                check("x_hold", int'(x_pixel), e_x);
            end
        end
    endtask

    task automatic run_frames(input int n, input int short_line);
        for (int f = 0; f < n; f++)
            for (int ln = 0; ln < VT; ln++)
                for (int px = 0; px < HT; px++)
                    if (!(f == 0 && ln == short_line && px == HT - 1))
                        strobe((px == HS) ? 0 : 1, (ln == VS) ? 0 : 1);
    endtask

    task automatic count_frame();
        de_count = 0;
        seen_de  = 0;
        run_frames(1, -1);
        check("de_per_frame", de_count, HV * VV);
        check("first_de_x", first_x, 0);
        check("first_de_y", first_y, 0);
        check("first_de_fs", first_fs, 1);
    endtask

    initial begin
        reset = 1'b1; pix_en = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_x", int'(x_pixel), 0);
        check("rst_y", int'(y_pixel), 0);
        check("rst_de", int'(DE), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_htotal", int'(h_total), 0);
        check("rst_vtotal", int'(v_total), 0);
        reset = 1'b0;
        $display("reset: outputs idle");

        run_frames(2, -1);
        check("no_lock_2_frames", int'(locked), 0);
        run_frames(1, -1);
        check("lock_3_frames", int'(locked), 1);
        rec_mode = 1;
        count_frame();
        rec_mode = 0;
        $display("lock: regular strobe, %0d DE pixels in locked frame", de_count);

        err_pulses = 0;
        run_frames(1, 1);
        check("short_line_err_pulses", err_pulses, 1);
        check("short_line_htotal", err_htotal, HT - 1);
        check("short_line_unlocked", int'(locked), 0);
        run_frames(3, -1);
        check("short_line_relock", int'(locked), 1);
        $display("short line: %0d timing_err pulse(s), relocked=%0d", err_pulses, locked);

        err_pulses = 0;
        for (int i = 0; i < 1100; i++) strobe(1, 1);
        check("hold_err_pulses", err_pulses, 1);
        check("hold_unlocked", int'(locked), 0);
        run_frames(3, -1);
        check("hold_relock", int'(locked), 1);
        $display("h_sync hold: %0d timing_err pulse(s)", err_pulses);

        strobe(1, 1);
        strobe(1, 1);
        check("de_before_reset", int'(DE), 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_de", int'(DE), 0);
        check("async_rst_locked", int'(locked), 0);
        check("async_rst_x", int'(x_pixel), 0);
        check("async_rst_y", int'(y_pixel), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        $display("async reset mid-line: DE=%0d locked=%0d", DE, locked);

        gap_mode = 1;
        run_frames(3, -1);
        check("gap_lock", int'(locked), 1);
        rec_mode = 2;
        count_frame();
        rec_mode = 0;
        check("replay_consumed", rec_q.size(), 0);
        $display("random gaps: %0d DE pixels in locked frame", de_count);

        for (int i = 0; i < 300; i++) strobe(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        run_frames(3, -1);
        check("junk_relock", int'(locked), 1);
        $display("random sync junk: relocked=%0d", locked);

`ifdef VGA_RX_ERR_CNT_EN
        gap_mode = 2;
        for (int i = 0; i < 300; i++) begin
            run_frames(1, 1);
            run_frames(2, -1);
        end
        check("err_count_sat", int'(err_count), 255);
        $display("error counter: err_count=%0d", err_count);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
